// File: rtl/tsv_link_arbiter.sv
// Weighted round-robin arbiter that shares one CAC-encoded TSV link among NREQ requesters.
// The winning word is registered into the encoder input; a source tag follows it down the encoder pipe.
module tsv_link_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned DW      = 20,
  parameter int unsigned BURST   = 4,
  parameter int unsigned ENC_LAT = 1,
  localparam int unsigned SW     = $clog2(NREQ)
) (
  input  logic               clock,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  input  logic               link_ready,
  output logic [DW-1:0]      enc_data,
  output logic               enc_valid,
  output logic               out_valid,
  output logic [SW-1:0]      out_src
);

  localparam int unsigned BW = $clog2(BURST + 1);

  typedef enum logic [0:0] {StIdle, StOwn} state_e;

  state_e             state_q;
  logic [SW-1:0]      owner_q;
  logic [SW-1:0]      rr_q;
  logic [BW-1:0]      burst_q;
  logic [DW-1:0]      enc_data_q;
  logic               enc_valid_q;
  logic [ENC_LAT-1:0] vld_pipe_q;
  logic [SW-1:0]      src_pipe_q [ENC_LAT];

  logic [DW-1:0]      req_words [NREQ];
  logic               win_vld;
  logic [SW-1:0]      win;
  logic [SW-1:0]      scan_start;
  logic               keep_owner;
  int unsigned        idx;

  for (genvar g = 0; g < NREQ; g++) begin : g_words
    assign req_words[g] = req_data[g*DW +: DW];
  end

  // Increment modulo NREQ, which need not be a power of two.
  function automatic logic [SW-1:0] wrap_inc(input logic [SW-1:0] v);
    if (32'(v) == NREQ - 1) return '0;
    return v + SW'(1);
  endfunction

  always_comb begin
    win_vld    = 1'b0;
    win        = '0;
    idx        = 0;
    keep_owner = (state_q == StOwn) && req_valid[owner_q] && (burst_q < BW'(BURST));
    scan_start = (state_q == StOwn) ? wrap_inc(owner_q) : rr_q;
    if (rst_n && link_ready) begin
      if (keep_owner) begin
        win_vld = 1'b1;
        win     = owner_q;
      end else begin
        // Scan ends on the owner itself, so a lone requester is re-granted without a bubble.
        for (int unsigned k = 0; k < NREQ; k++) begin
          idx = (32'(scan_start) + k) % NREQ;
          if (!win_vld && req_valid[SW'(idx)]) begin
            win_vld = 1'b1;
            win     = SW'(idx);
          end
        end
      end
    end
    req_ready = '0;
    if (win_vld) req_ready[win] = 1'b1;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      owner_q     <= '0;
      rr_q        <= '0;
      burst_q     <= '0;
      enc_data_q  <= '0;
      enc_valid_q <= 1'b0;
      vld_pipe_q  <= '0;
      for (int i = 0; i < ENC_LAT; i++) src_pipe_q[i] <= '0;
    end else begin
      if (win_vld) begin
        enc_data_q  <= req_words[win];
        enc_valid_q <= 1'b1;
        owner_q     <= win;
        state_q     <= StOwn;
        burst_q     <= (win == owner_q && state_q == StOwn && burst_q < BW'(BURST)) ?
                       burst_q + BW'(1) : BW'(1);
      end else begin
        // enc_data holds so the TSV bundle stays quiet while idle.
        enc_valid_q <= 1'b0;
        if (link_ready && !(|req_valid) && state_q == StOwn) begin
          state_q <= StIdle;
          rr_q    <= wrap_inc(owner_q);
          burst_q <= '0;
        end
      end
      vld_pipe_q[0] <= enc_valid_q;
      src_pipe_q[0] <= owner_q;
      for (int i = 1; i < ENC_LAT; i++) begin
        vld_pipe_q[i] <= vld_pipe_q[i-1];
        src_pipe_q[i] <= src_pipe_q[i-1];
      end
    end
  end

  assign enc_data  = enc_data_q;
  assign enc_valid = enc_valid_q;
  assign out_valid = vld_pipe_q[ENC_LAT-1];
  assign out_src   = src_pipe_q[ENC_LAT-1];

endmodule

// File: tb/tb_tsv_link_arbiter.sv
// Self-checking bench for tsv_link_arbiter: directed vector table, corner sequences and random
// traffic against a rotation-order reference model with a per-source scoreboard.
`timescale 1ns/1ps
module tb_tsv_link_arbiter;
  localparam int NREQ  = 4;
  localparam int DW    = 20;
  localparam int BURST = 4;

  logic        clock = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [79:0] req_data;
  logic [3:0]  req_ready;
  logic        link_ready;
  logic [19:0] enc_data;
  logic        enc_valid;
  logic        out_valid;
  logic [1:0]  out_src;

  int errors = 0;
  int checks = 0;

  always #1 clock = ~clock;

  tsv_link_arbiter #(.NREQ(NREQ), .DW(DW), .BURST(BURST), .ENC_LAT(1)) dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .link_ready(link_ready),
    .enc_data  (enc_data),
    .enc_valid (enc_valid),
    .out_valid (out_valid),
    .out_src   (out_src)
  );

  // Reference model: who currently owns the link, how many words in a row it has had,
  // and where the rotation resumes after the link went idle.
  int          m_owner, m_cnt, m_rr, m_enc_src, m_out_src;
  bit          m_own, m_enc_valid, m_out_valid;
  logic [19:0] m_enc_data;
  logic [19:0] sbq [4][$];
  logic [19:0] enc_d1;

  typedef struct {
    logic [3:0] v;
    logic       lr;
    logic [3:0] ready;
  } vec_t;
  vec_t tbl [31];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Owner keeps the link while valid and under the burst limit; otherwise the first valid
  // requester in circular order after the owner (or after the resume point when idle) wins.
  function automatic int pick(input logic [3:0] v, input logic lr);
    int base;
    if (!lr) return -1;
    if (m_own && v[m_owner] && m_cnt < BURST) return m_owner;
    base = m_own ? m_owner + 1 : m_rr;
    for (int k = 0; k < NREQ; k++)
      if (v[(base + k) % NREQ]) return (base + k) % NREQ;
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = 0; m_cnt = 0; m_rr = 0; m_own = 0;
    m_enc_data = '0; m_enc_valid = 0; m_enc_src = 0;
    m_out_valid = 0; m_out_src = 0; enc_d1 = '0;
    for (int i = 0; i < NREQ; i++) sbq[i].delete();
  endtask

  task automatic check_regs();
    chk("enc_valid", enc_valid, m_enc_valid);
    chk("enc_data", enc_data, m_enc_data);
    chk("out_valid", out_valid, m_out_valid);
    if (m_out_valid) chk("out_src", out_src, m_out_src);
    if (out_valid === 1'b1) begin
      if (sbq[out_src].size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_word: src %0d word %0h has no pending entry", out_src, enc_d1);
      end else begin
        chk("sb_word", enc_d1, sbq[out_src].pop_front());
      end
    end
    enc_d1 = enc_data;
  endtask

  // Called at a falling edge: check registered outputs, drive, check req_ready, advance model.
  task automatic cycle(input logic [3:0] v, input logic lr, input logic [79:0] d,
                       input logic [4:0] exp, output int w);
    check_regs();
    req_valid  = v;
    link_ready = lr;
    req_data   = d;
    #0.1;
    w = pick(v, lr);
    chk("req_ready", req_ready, (w < 0) ? 0 : (1 << w));
    if (exp[4]) chk("vec_ready", req_ready, exp[3:0]);
    m_out_valid = m_enc_valid;
    m_out_src   = m_enc_src;
    if (w >= 0) begin
      m_enc_data  = d[w*20 +: 20];
      m_enc_valid = 1;
      m_enc_src   = w;
      sbq[w].push_back(d[w*20 +: 20]);
      m_cnt   = (m_own && w == m_owner && m_cnt < BURST) ? m_cnt + 1 : 1;
      m_owner = w;
      m_own   = 1;
    end else begin
      m_enc_valid = 0;
      if (lr && v == 0 && m_own) begin
        m_own = 0;
        m_rr  = (m_owner + 1) % NREQ;
        m_cnt = 0;
      end
    end
    @(negedge clock);
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    #0.3;
    @(negedge clock);
    model_reset();
    rst_n = 1'b1;
  endtask

  function automatic logic [79:0] mkdata(input int step);
    logic [79:0] d;
    for (int p = 0; p < NREQ; p++) d[p*20 +: 20] = {4'(p), 4'h0, 12'(step)};
    return d;
  endfunction

  initial begin
    int          w;
    logic [3:0]  v;
    logic        lr;
    logic [79:0] d;

    tbl[0]  = '{4'b1111, 1'b1, 4'b0001}; tbl[1]  = '{4'b1111, 1'b1, 4'b0001};
    tbl[2]  = '{4'b1111, 1'b1, 4'b0001}; tbl[3]  = '{4'b1111, 1'b1, 4'b0001};
    tbl[4]  = '{4'b1111, 1'b1, 4'b0010}; tbl[5]  = '{4'b1111, 1'b1, 4'b0010};
    tbl[6]  = '{4'b1111, 1'b1, 4'b0010}; tbl[7]  = '{4'b1111, 1'b1, 4'b0010};
    tbl[8]  = '{4'b1111, 1'b1, 4'b0100}; tbl[9]  = '{4'b1111, 1'b1, 4'b0100};
    tbl[10] = '{4'b1111, 1'b1, 4'b0100}; tbl[11] = '{4'b1111, 1'b1, 4'b0100};
    tbl[12] = '{4'b1111, 1'b1, 4'b1000}; tbl[13] = '{4'b1111, 1'b1, 4'b1000};
    tbl[14] = '{4'b1111, 1'b1, 4'b1000}; tbl[15] = '{4'b1111, 1'b1, 4'b1000};
    tbl[16] = '{4'b1111, 1'b1, 4'b0001};
    tbl[17] = '{4'b1111, 1'b0, 4'b0000}; tbl[18] = '{4'b1111, 1'b0, 4'b0000};
    tbl[19] = '{4'b1111, 1'b1, 4'b0001};
    tbl[20] = '{4'b0010, 1'b1, 4'b0010}; tbl[21] = '{4'b0010, 1'b1, 4'b0010};
    tbl[22] = '{4'b1000, 1'b1, 4'b1000}; tbl[23] = '{4'b1000, 1'b1, 4'b1000};
    tbl[24] = '{4'b1000, 1'b1, 4'b1000}; tbl[25] = '{4'b1000, 1'b1, 4'b1000};
    tbl[26] = '{4'b1000, 1'b1, 4'b1000};
    tbl[27] = '{4'b0000, 1'b1, 4'b0000};
    tbl[28] = '{4'b0110, 1'b1, 4'b0010};
    tbl[29] = '{4'b0000, 1'b0, 4'b0000};
    tbl[30] = '{4'b0100, 1'b1, 4'b0100};

    rst_n = 1'b0; req_valid = '0; link_ready = 1'b0; req_data = '0;
    model_reset();
    repeat (2) @(negedge clock);
    rst_n = 1'b1;

    // Asynchronous reset in the middle of a burst clears outputs before the next edge.
    cycle(4'b1111, 1'b1, mkdata(100), 5'b0, w);
    cycle(4'b1111, 1'b1, mkdata(101), 5'b0, w);
    #0.5;
    rst_n = 1'b0;
    #0.1;
    chk("rst_enc_valid", enc_valid, 0);
    chk("rst_enc_data", enc_data, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_src", out_src, 0);
    chk("rst_req_ready", req_ready, 0);
    @(negedge clock);
    model_reset();
    rst_n = 1'b1;

    // Vector table: rotation order, stall, owner drop, lone requester, idle resume point.
    foreach (tbl[i]) cycle(tbl[i].v, tbl[i].lr, mkdata(i), {1'b1, tbl[i].ready}, w);

    // Lone requester 2 streams 10 words through the burst boundary without a bubble.
    reset_pulse();
    for (int i = 0; i < 10; i++) begin
      d = '0;
      d[40 +: 20] = 20'(i);
      cycle(4'b0100, 1'b1, d, 5'b10100, w);
    end
    repeat (2) cycle(4'b0000, 1'b1, '0, 5'b10000, w);

    // Link stall holds the encoder word and the burst count.
    reset_pulse();
    d = mkdata(7);
    d[19:0] = 20'hABCDE;
    cycle(4'b0011, 1'b1, d, 5'b10001, w);
    d[19:0] = 20'h12345;
    repeat (3) cycle(4'b0011, 1'b0, d, 5'b10000, w);
    chk("hold_data", enc_data, 20'hABCDE);
    repeat (3) cycle(4'b0011, 1'b1, d, 5'b10001, w);
    cycle(4'b0011, 1'b1, d, 5'b10010, w);
    repeat (2) cycle(4'b0000, 1'b1, '0, 5'b0, w);

    // Random traffic: requesters hold valid/data until accepted, with occasional withdrawals.
    reset_pulse();
    v = '0;
    d = '0;
    for (int n = 0; n < 4000; n++) begin
      for (int p = 0; p < NREQ; p++) begin
        if (!v[p] && $urandom_range(0, 99) < 50) begin
          v[p] = 1'b1;
          d[p*20 +: 20] = 20'($urandom % 635622);
        end else if (v[p] && $urandom_range(0, 99) < 3) begin
          v[p] = 1'b0;
        end
      end
      lr = ($urandom_range(0, 99) < 85);
      cycle(v, lr, d, 5'b0, w);
      if (w >= 0) v[w] = 1'b0;
    end
    repeat (4) cycle(4'b0000, 1'b1, d, 5'b0, w);
    for (int p = 0; p < NREQ; p++) chk("sb_drain", sbq[p].size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
